kbd_led_ctrl: RTL and testbench

Host-to-device command sequencer for the PS/2 keyboard port. On request it sends the two-byte Set-LEDs command (0xED, then the LED byte) to the keyboard, driving the open-drain PS/2 lines itself. It checks for the device ACK bit and the 0xFA acknowledge on each byte, resends on 0xFE, and reports done or error. It sits beside the scancode receiver: its `tx_active` output makes the receiver ignore line activity while a byte is being transmitted, and it consumes the receiver's byte stream (`rx_valid`/`rx_byte`) for responses.

---
 rtl/kbd_led_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_kbd_led_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_led_ctrl.sv
// kbd_led_ctrl: host-to-device Set-LEDs sequencer for the PS/2 keyboard port.
// Sends 0xED followed by the LED byte, drives the open-drain lines through
// the *_oe outputs, checks the device line ACK and the 0xFA/0xFE reply to
// each byte, and pulses done or err when the exchange ends.
module kbd_led_ctrl #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic       led_req,
  input  logic [2:0] led_val,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       busy,
  output logic       tx_active,
  output logic       done,
  output logic       err
);

  localparam int INH_W = (INHIBIT_CYCLES < 2) ? 1 : $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] RESP_ACK     = 8'hFA;
  localparam logic [7:0] RESP_RESEND  = 8'hFE;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_RESP = 3'd5
  } state_t;

  state_t           state;
  logic [7:0]       clk_hist;
  logic [1:0]       data_sync;
  logic             fall;
  logic             phase;
  logic [2:0]       led;
  logic [7:0]       txbyte;
  logic [3:0]       bitcnt;
  logic [INH_W-1:0] inh;
  logic [TMO_W-1:0] tmo;
  logic [RTY_W-1:0] retry;

  // Odd parity bit for a PS/2 frame: makes the count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // ps2clk filter history; a fall is four high samples followed by four low ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_hist <= 8'h00;
    end else begin
      clk_hist <= {clk_hist[6:0], ps2clk};
    end
  end

  // Two-stage synchroniser for the data pad, used only for the device ACK bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_sync <= 2'b11;
    end else begin
      data_sync <= {data_sync[0], ps2data};
    end
  end

  assign fall   = (clk_hist == 8'hF0);
  assign txbyte = phase ? {5'b00000, led} : CMD_SET_LEDS;

  // Sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= 1'b0;
      led        <= 3'b000;
      bitcnt     <= 4'd0;
      inh        <= '0;
      tmo        <= '0;
      retry      <= '0;
      ps2clk_oe  <= 1'b0;
      ps2data_oe <= 1'b0;
      busy       <= 1'b0;
      tx_active  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      // Watchdog restarts on every filtered clock fall; state entries clear it below.
      if (fall) begin
        tmo <= '0;
      end else begin
        tmo <= tmo + TMO_W'(1);
      end

      case (state)
        IDLE: begin
          tmo <= '0;
          inh <= '0;
          if (led_req) begin
            led        <= led_val;
            phase      <= 1'b0;
            retry      <= '0;
            state      <= INHIBIT;
            ps2clk_oe  <= 1'b1;
            ps2data_oe <= 1'b0;
            busy       <= 1'b1;
            tx_active  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        INHIBIT: begin
          tmo <= '0;
          if (inh == INH_LAST) begin
            // Release the clock and pull data low in the same edge: start bit.
            state      <= START;
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b1;
            inh        <= '0;
          end else begin
            inh <= inh + INH_W'(1);
          end
        end

        START: begin
          if (tmo == TMO_LAST) begin
            state      <= IDLE;
            err        <= 1'b1;
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            busy       <= 1'b0;
            tx_active  <= 1'b0;
          end else begin
            state  <= SEND;
            bitcnt <= 4'd0;
            tmo    <= '0;
          end
        end

        SEND: begin
          if (fall) begin
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt < 4'd8) begin
              ps2data_oe <= ~txbyte[bitcnt[2:0]];
            end else if (bitcnt == 4'd8) begin
              ps2data_oe <= ~odd_parity(txbyte);
            end else begin
              // Stop bit: line released, device will answer on the next fall.
              ps2data_oe <= 1'b0;
              state      <= ACK;
            end
          end else if (tmo == TMO_LAST) begin
            state      <= IDLE;
            err        <= 1'b1;
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            busy       <= 1'b0;
            tx_active  <= 1'b0;
          end else begin
            state <= SEND;
          end
        end

        ACK: begin
          if (fall) begin
            if (!data_sync[1]) begin
              state     <= WAIT_RESP;
              tx_active <= 1'b0;
              tmo       <= '0;
            end else begin
              state      <= IDLE;
              err        <= 1'b1;
              ps2clk_oe  <= 1'b0;
              ps2data_oe <= 1'b0;
              busy       <= 1'b0;
              tx_active  <= 1'b0;
            end
          end else if (tmo == TMO_LAST) begin
            state      <= IDLE;
            err        <= 1'b1;
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            busy       <= 1'b0;
            tx_active  <= 1'b0;
          end else begin
            state <= ACK;
          end
        end

        WAIT_RESP: begin
          if (rx_valid) begin
            if ((rx_byte == RESP_ACK) && !phase) begin
              // Command byte accepted: move on to the LED argument byte.
              phase      <= 1'b1;
              retry      <= '0;
              state      <= INHIBIT;
              inh        <= '0;
              tmo        <= '0;
              ps2clk_oe  <= 1'b1;
              ps2data_oe <= 1'b0;
              tx_active  <= 1'b1;
            end else if (rx_byte == RESP_ACK) begin
              state      <= IDLE;
              done       <= 1'b1;
              ps2clk_oe  <= 1'b0;
              ps2data_oe <= 1'b0;
              busy       <= 1'b0;
              tx_active  <= 1'b0;
            end else if ((rx_byte == RESP_RESEND) && (retry < RTY_MAX)) begin
              // Resend the same byte; phase is left unchanged.
              retry      <= retry + RTY_W'(1);
              state      <= INHIBIT;
              inh        <= '0;
              tmo        <= '0;
              ps2clk_oe  <= 1'b1;
              ps2data_oe <= 1'b0;
              tx_active  <= 1'b1;
            end else begin
              state      <= IDLE;
              err        <= 1'b1;
              ps2clk_oe  <= 1'b0;
              ps2data_oe <= 1'b0;
              busy       <= 1'b0;
              tx_active  <= 1'b0;
            end
          end else if (tmo == TMO_LAST) begin
            state      <= IDLE;
            err        <= 1'b1;
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            busy       <= 1'b0;
            tx_active  <= 1'b0;
          end else begin
            state <= WAIT_RESP;
          end
        end

        default: begin
          state      <= IDLE;
          ps2clk_oe  <= 1'b0;
          ps2data_oe <= 1'b0;
          busy       <= 1'b0;
          tx_active  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_led_ctrl.sv
// Directed bench for kbd_led_ctrl with a PS/2 device model and a frame scoreboard.
module tb_kbd_led_ctrl;

  localparam int INH = 20;
  localparam int TMO = 1000;
  localparam int RTY = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       led_req;
  logic [2:0] led_val;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       dev_clk;
  logic       dev_data;
  logic       ps2clk;
  logic       ps2data;
  logic       ps2clk_oe;
  logic       ps2data_oe;
  logic       busy;
  logic       tx_active;
  logic       done;
  logic       err;

  // Open-drain wires: low if either side pulls.
  assign ps2clk  = dev_clk  & ~ps2clk_oe;
  assign ps2data = dev_data & ~ps2data_oe;

  kbd_led_ctrl #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY(RTY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2clk(ps2clk),
    .ps2data(ps2data),
    .ps2clk_oe(ps2clk_oe),
    .ps2data_oe(ps2data_oe),
    .led_req(led_req),
    .led_val(led_val),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .busy(busy),
    .tx_active(tx_active),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  int   done_cnt = 0;
  int   err_cnt = 0;
  int   dbl_pulse = 0;
  int   inh_cnt = 0;
  int   inh_len = 0;
  int   last_inh = 0;
  logic done_d = 1'b0;
  logic err_d = 1'b0;

  // Pulse counters and clock-inhibit length measurement.
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if ((done && done_d) || (err && err_d)) dbl_pulse <= dbl_pulse + 1;
    done_d <= done;
    err_d  <= err;
    if (ps2clk_oe) begin
      inh_len <= inh_len + 1;
    end else if (inh_len != 0) begin
      last_inh <= inh_len;
      inh_len  <= 0;
      inh_cnt  <= inh_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [2:0] v);
    led_val = v;
    led_req = 1'b1;
    tick();
    led_req = 1'b0;
  endtask

  // Wait for the clock inhibit, then for its release with the start bit.
  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (ps2clk_oe !== 1'b1 && n < 50) begin tick(); n++; end
    check({tag, "_inhibit"}, ps2clk_oe, 1);
    n = 0;
    while (ps2clk_oe === 1'b1 && n < INH + 50) begin tick(); n++; end
    check({tag, "_clk_release"}, ps2clk_oe, 0);
    check({tag, "_start_bit"}, ps2data_oe, 1);
    check({tag, "_tx_active"}, tx_active, 1);
  endtask

  // Device side of one host-to-device frame; compares it with the scoreboard head.
  task automatic dev_frame(input string tag, input logic give_ack);
    logic [10:0] bits;
    logic [7:0]  got;
    logic [7:0]  expb;
    int          ones;
    repeat (12) tick();
    check({tag, "_inhibit_len"}, last_inh, INH);
    bits[0] = ps2data;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (8) tick();
      bits[k] = ps2data;
      repeat (2) tick();
      dev_clk = 1'b1;
      repeat (10) tick();
    end
    dev_data = give_ack ? 1'b0 : 1'b1;
    repeat (5) tick();
    dev_clk = 1'b0;
    repeat (10) tick();
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 8; i++) got[i] = bits[i + 1];
    check({tag, "_pending"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      expb = exp_q.pop_front();
      ones = $countones(expb);
      check({tag, "_byte"}, got, expb);
      check({tag, "_parity"}, bits[9], (ones % 2 == 0) ? 1 : 0);
    end
    check({tag, "_start"}, bits[0], 0);
    check({tag, "_stop"}, bits[10], 1);
  endtask

  task automatic respond(input logic [7:0] b);
    repeat (3) tick();
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  initial begin
    int d0;
    int e0;
    int i0;
    int n;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    reset    = 1'b1;
    led_req  = 1'b0;
    led_val  = 3'b000;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    repeat (3) tick();
    check("rst_clk_oe", ps2clk_oe, 0);
    check("rst_data_oe", ps2data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_active", tx_active, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    repeat (10) tick();

    // Nominal two-byte exchange; led_val changes mid-transfer must not matter.
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(8'hED);
    exp_q.push_back(8'h05);
    start_req(3'b101);
    check("nom_busy", busy, 1);
    check("nom_clk_oe", ps2clk_oe, 1);
    led_val = 3'b010;
    wait_start("nom1");
    dev_frame("nom1", 1'b1);
    check("nom_wait_busy", busy, 1);
    check("nom_wait_txa", tx_active, 0);
    respond(8'hFA);
    check("nom_reinhibit", ps2clk_oe, 1);
    wait_start("nom2");
    dev_frame("nom2", 1'b1);
    respond(8'hFA);
    check("nom_done", done, 1);
    check("nom_busy_fall", busy, 0);
    check("nom_err", err, 0);
    tick();
    check("nom_done_pulse", done, 0);
    check("nom_done_cnt", done_cnt - d0, 1);
    check("nom_err_cnt", err_cnt - e0, 0);
    repeat (5) tick();

    // One resend of the argument byte.
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(8'hED);
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h05);
    start_req(3'b101);
    wait_start("rs1");
    dev_frame("rs1", 1'b1);
    respond(8'hFA);
    wait_start("rs2");
    dev_frame("rs2", 1'b1);
    respond(8'hFE);
    check("rs_busy", busy, 1);
    check("rs_reinhibit", ps2clk_oe, 1);
    check("rs_no_done", done, 0);
    wait_start("rs3");
    dev_frame("rs3", 1'b1);
    respond(8'hFA);
    check("rs_done", done, 1);
    tick();
    check("rs_done_cnt", done_cnt - d0, 1);
    check("rs_err_cnt", err_cnt - e0, 0);
    repeat (5) tick();

    // Retry exhaustion on the command byte.
    d0 = done_cnt; e0 = err_cnt;
    for (int r = 0; r <= RTY; r++) exp_q.push_back(8'hED);
    start_req(3'b011);
    for (int r = 0; r <= RTY; r++) begin
      wait_start("rx");
      dev_frame("rx", 1'b1);
      respond(8'hFE);
      if (r < RTY) begin
        check("rx_no_err", err, 0);
        check("rx_retry_inhibit", ps2clk_oe, 1);
      end else begin
        check("rx_err", err, 1);
        check("rx_clk_rel", ps2clk_oe, 0);
        check("rx_data_rel", ps2data_oe, 0);
        check("rx_busy", busy, 0);
      end
    end
    tick();
    check("rx_err_pulse", err, 0);
    check("rx_err_cnt", err_cnt - e0, 1);
    check("rx_done_cnt", done_cnt - d0, 0);
    repeat (5) tick();

    // Device does not pull data low on the eleventh fall.
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(8'hED);
    start_req(3'b001);
    wait_start("na");
    dev_frame("na", 1'b0);
    check("na_err_cnt", err_cnt - e0, 1);
    check("na_busy", busy, 0);
    check("na_done_cnt", done_cnt - d0, 0);
    repeat (5) tick();

    // Device never clocks after the start bit.
    e0 = err_cnt;
    start_req(3'b111);
    wait_start("to");
    n = 0;
    while (err !== 1'b1 && n < TMO + 200) begin tick(); n++; end
    check("to_err_seen", err, 1);
    check("to_latency_window", (n >= TMO - 1 && n <= TMO + 2), 1);
    tick();
    check("to_clk_rel", ps2clk_oe, 0);
    check("to_data_rel", ps2data_oe, 0);
    check("to_err_cnt", err_cnt - e0, 1);
    repeat (5) tick();

    // Reset after the fourth data bit, with a stray request while busy.
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    start_req(3'b110);
    wait_start("mr");
    repeat (12) tick();
    for (int k = 1; k <= 4; k++) begin
      dev_clk = 1'b0;
      repeat (10) tick();
      dev_clk = 1'b1;
      repeat (10) tick();
    end
    led_req = 1'b1;
    tick();
    led_req = 1'b0;
    check("mr_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    check("mr_clk_oe", ps2clk_oe, 0);
    check("mr_data_oe", ps2data_oe, 0);
    check("mr_busy", busy, 0);
    check("mr_tx_active", tx_active, 0);
    check("mr_done", done, 0);
    check("mr_err", err, 0);
    reset = 1'b0;
    repeat (100) tick();
    check("mr_one_transfer", inh_cnt - i0, 1);
    check("mr_idle_busy", busy, 0);
    check("mr_done_cnt", done_cnt - d0, 0);
    check("mr_err_cnt", err_cnt - e0, 0);

    check("queue_empty", exp_q.size(), 0);
    check("single_cycle_pulses", dbl_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
